// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM state type and output saturation for the FIR MAC sequencer
package fir_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int COEF_W_DEF = 8;
    localparam int TAPS_DEF   = 4;
    localparam int OUT_W_DEF  = 16;

    // Saturation is evaluated at this fixed width so one function serves any ACC_W/OUT_W pair.
    localparam int SAT_W = 64;

    // Accumulator must hold TAPS full-precision products without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    // Clamp a sign-extended accumulator value to the signed range of out_w bits.
    function automatic logic signed [SAT_W-1:0] sat_to_out(input logic signed [SAT_W-1:0] v,
                                                          input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - combinational signed multiply-accumulate with saturated view of the sum
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int ACC_W  = acc_width(DATA_W_DEF, COEF_W_DEF, TAPS_DEF),
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [COEF_W-1:0] i_c,
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [ACC_W-1:0]  o_acc_next,
    output logic signed [OUT_W-1:0]  o_sat
);

    localparam int P_W = DATA_W + COEF_W;

    logic signed [P_W-1:0]   w_x_ext;
    logic signed [P_W-1:0]   w_c_ext;
    logic signed [P_W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [SAT_W-1:0] w_sum_ext;

    // Operands are widened to the product width first so the multiply is exact.
    assign w_x_ext    = {{COEF_W{i_x[DATA_W-1]}}, i_x};
    assign w_c_ext    = {{DATA_W{i_c[COEF_W-1]}}, i_c};
    assign w_prod     = w_x_ext * w_c_ext;
    assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
    assign o_acc_next = i_acc + w_prod_ext;
    assign w_sum_ext  = {{(SAT_W-ACC_W){o_acc_next[ACC_W-1]}}, o_acc_next};
    assign o_sat      = OUT_W'(sat_to_out(w_sum_ext, OUT_W));

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed single-multiplier FIR with handshaked in/out and coefficient bank
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int TAPS   = TAPS_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_err,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     busy
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int AW    = $clog2(TAPS);

    fir_state_t               r_state;
    fir_state_t               w_state_next;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [COEF_W-1:0] r_c [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_k;
    logic                     r_m_valid;
    logic [OUT_W-1:0]         r_m_data;
    logic                     r_coef_err;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_coef_ok;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [OUT_W-1:0]  w_sat;

    assign w_accept  = s_valid && (r_state == IDLE);
    assign w_last    = (r_k == AW'(TAPS - 1));
    assign w_coef_ok = coef_we && (r_state == IDLE) && (int'(coef_addr) < TAPS);

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .i_x        (r_x[r_k]),
        .i_c        (r_c[r_k]),
        .i_acc      (r_acc),
        .o_acc_next (w_acc_next),
        .o_sat      (w_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: accept -> TAPS MAC cycles -> hold result until taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (s_valid) w_state_next = RUN;
            RUN:     if (w_last)  w_state_next = DONE;
            DONE:    if (m_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        s_ready = (r_state == IDLE);
        busy    = (r_state != IDLE);
    end

    // Delay line, accumulator, tap counter and output result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < TAPS; j++) begin
                r_x[j] <= '0;
            end
            r_acc     <= '0;
            r_k       <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_accept) begin
                r_x[0] <= s_data;
                for (int j = 1; j < TAPS; j++) begin
                    r_x[j] <= r_x[j-1];
                end
                r_acc <= '0;
                r_k   <= '0;
            end
            if (r_state == RUN) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + AW'(1);
                if (w_last) begin
                    r_m_data  <= w_sat;
                    r_m_valid <= 1'b1;
                end
            end
            if ((r_state == DONE) && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // Coefficient bank; writes outside IDLE or out of range are dropped and flagged next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < TAPS; j++) begin
                r_c[j] <= COEF_W'(1);
            end
            r_coef_err <= 1'b0;
        end else begin
            if (w_coef_ok) begin
                r_c[coef_addr] <= coef_wdata;
            end
            r_coef_err <= coef_we && !w_coef_ok;
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign coef_err = r_coef_err;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed table-driven bench for fir_mac_sequencer
module tb_fir_mac_sequencer;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_wdata;
    logic        coef_err;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit rst_first;
        int coef_mode;
        int din;
        int exp;
    } vec_t;

    vec_t vecs[18];

    fir_mac_sequencer #(
        .DATA_W (8),
        .COEF_W (8),
        .TAPS   (4),
        .OUT_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        coef_we = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = 2'(addr);
        coef_wdata = 8'(val);
        tick();
        coef_we = 1'b0;
        check($sformatf("coef_write_noerr_a%0d", addr), 32'(coef_err), 0);
    endtask

    task automatic set_coefs(input int mode);
        if (mode == 1) begin
            for (int a = 0; a < 4; a++) write_coef(a, a + 1);
        end else if (mode == 2) begin
            for (int a = 0; a < 4; a++) write_coef(a, 127);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready) check({name, "_ready_timeout"}, 32'(s_ready), 1);
    endtask

    task automatic wait_mvalid(input string name, output int edges);
        edges = 0;
        while (!m_valid && edges < 20) begin
            tick();
            edges++;
        end
        if (!m_valid) check({name, "_mvalid_timeout"}, 32'(m_valid), 1);
    endtask

    task automatic run_sample(input string name, input int din, input int exp);
        int edges;
        wait_ready(name);
        s_valid = 1'b1;
        s_data  = 8'(din);
        tick();
        s_valid = 1'b0;
        check({name, "_sready_busy"}, 32'(s_ready), 0);
        wait_mvalid(name, edges);
        check({name, "_latency"}, edges, 4);
        check({name, "_data"}, 32'($signed(m_data)), exp);
        tick();
        check({name, "_mvalid_clear"}, 32'(m_valid), 0);
    endtask

    initial begin
        int edges;
        bit seen;

        reset      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        m_ready    = 1'b1;

        vecs[0]  = '{1, 0,    5,      5};
        vecs[1]  = '{0, 0,   10,     15};
        vecs[2]  = '{0, 0,   15,     30};
        vecs[3]  = '{0, 0,   20,     50};
        vecs[4]  = '{0, 0,   25,     70};
        vecs[5]  = '{0, 0,   30,     90};
        vecs[6]  = '{1, 1,    1,      1};
        vecs[7]  = '{0, 0,    0,      2};
        vecs[8]  = '{0, 0,    0,      3};
        vecs[9]  = '{0, 0,    0,      4};
        vecs[10] = '{1, 2,  127,  16129};
        vecs[11] = '{0, 0,  127,  32258};
        vecs[12] = '{0, 0,  127,  32767};
        vecs[13] = '{0, 0,  127,  32767};
        vecs[14] = '{1, 2, -128, -16256};
        vecs[15] = '{0, 0, -128, -32512};
        vecs[16] = '{0, 0, -128, -32768};
        vecs[17] = '{0, 0, -128, -32768};

        #2;
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_coef_err", 32'(coef_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst_first) apply_reset();
            set_coefs(vecs[i].coef_mode);
            run_sample($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
        end

        // Backpressure: result held in DONE, offered sample refused.
        apply_reset();
        m_ready = 1'b0;
        wait_ready("bp");
        s_valid = 1'b1;
        s_data  = 8'd5;
        tick();
        s_valid = 1'b0;
        wait_mvalid("bp", edges);
        for (int c = 0; c < 6; c++) begin
            s_valid = 1'b1;
            s_data  = 8'd99;
            tick();
            check($sformatf("bp_hold_valid_%0d", c), 32'(m_valid), 1);
            check($sformatf("bp_hold_data_%0d", c), 32'($signed(m_data)), 5);
            check($sformatf("bp_hold_sready_%0d", c), 32'(s_ready), 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(m_valid), 0);
        check("bp_release_sready", 32'(s_ready), 1);
        run_sample("bp_next", 7, 12);

        // Coefficient write and sample accept in the same IDLE cycle.
        apply_reset();
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd3;
        s_valid    = 1'b1;
        s_data     = 8'd4;
        tick();
        coef_we = 1'b0;
        s_valid = 1'b0;
        check("wa_coef_err", 32'(coef_err), 0);
        wait_mvalid("wa", edges);
        check("wa_data", 32'($signed(m_data)), 12);
        tick();

        // Coefficient write while RUN is rejected with a one-cycle error pulse.
        apply_reset();
        s_valid = 1'b1;
        s_data  = 8'd2;
        tick();
        s_valid    = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd50;
        tick();
        coef_we = 1'b0;
        check("run_wr_err_pulse", 32'(coef_err), 1);
        tick();
        check("run_wr_err_clear", 32'(coef_err), 0);
        wait_mvalid("run_wr", edges);
        check("run_wr_data", 32'($signed(m_data)), 2);
        tick();
        run_sample("run_wr_next", 3, 5);

        // Asynchronous reset mid-RUN discards the pending result and restores coefficients.
        apply_reset();
        write_coef(0, 5);
        s_valid = 1'b1;
        s_data  = 8'd9;
        tick();
        s_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_m_valid", 32'(m_valid), 0);
        check("mid_rst_s_ready", 32'(s_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m_valid) seen = 1'b1;
        end
        check("mid_rst_no_late_valid", 32'(seen), 0);
        run_sample("mid_rst_next", 7, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed controller for a single-multiplier FIR datapath.
- Accepts one input sample per handshake and shifts it into a TAPS-deep delay line.
- Sequences one multiply-accumulate per cycle over all taps, then presents a saturated result on an output handshake.
- Holds a runtime-writable coefficient bank. Sits between the sample source and downstream consumer in place of a fully parallel FIR.

Parameters:
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- TAPS, 4, number of filter taps (≥2)
- OUT_W, 16, signed output width
- Derived, not overridable: ACC_W = DATA_W+COEF_W+$clog2(TAPS); AW = $clog2(TAPS)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index to write
- coef_wdata  in  COEF_W  signed coefficient value
- coef_err  out  1  one-cycle pulse: rejected coefficient write
- m_valid  out  1  output result valid
- m_ready  in  1  downstream accepts result
- m_data  out  OUT_W  signed saturated filter output
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state (while reset=0, immediately, independent of clk):
  - state=IDLE; delay line x[0..TAPS-1]=0; acc=0; tap counter k=0.
  - All coefficients c[k]=1.
  - m_valid=0, m_data=0, coef_err=0, busy=0, s_ready=1.
- States: IDLE, RUN, DONE. s_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE, s_valid=1 (accept edge):
  - x[0]<=s_data; x[j]<=x[j-1] for j≥1.
  - acc<=0, k<=0; go RUN.
- RUN:
  - Each edge: acc<=acc+x[k]*c[k], full signed precision in ACC_W; k<=k+1.
  - The multiply reads the post-shift delay line, so the new sample is x[0].
  - On the edge where k==TAPS-1: m_data<=sat(acc+x[k]*c[k]), m_valid<=1, go DONE.
- DONE:
  - m_valid and m_data held stable until m_ready=1.
  - On that edge: m_valid<=0, go IDLE.
  - m_ready is ignored outside DONE.
- Latency and throughput:
  - m_valid rises TAPS clock edges after the accept edge.
  - Minimum sample period is TAPS+2 cycles: accept, TAPS MACs, ≥1 DONE cycle.
- Saturation:
  - Values above 2^(OUT_W-1)-1 clamp to 2^(OUT_W-1)-1.
  - Values below -2^(OUT_W-1) clamp to -2^(OUT_W-1).
  - Otherwise the value passes through sign-extended or truncated exactly.
- Coefficient writes:
  - Accepted only when state==IDLE and coef_addr<TAPS; c[coef_addr]<=coef_wdata on that edge.
  - Otherwise the write is ignored and coef_err pulses high for exactly one cycle on the following cycle.
  - Write plus sample accept in the same IDLE cycle: the write applies, and the MAC run uses the new coefficient.
- Output is y[n] = Σ c[k]·x[n-k], with x history zero after reset.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to the reset state; the pending result is discarded.
  - No m_valid pulse appears after release.

Decomposition:
- Package fir_pkg holds:
  - width constants and the ACC_W rule;
  - state enum {IDLE, RUN, DONE};
  - sat_to_out function, parameterized on ACC_W/OUT_W.
- Sub-module fir_mac: combinational signed product plus accumulate adder, with saturation output. The sequencer owns all registers and the FSM.

Test Plan:
- Defaults (coefs all 1), m_ready=1:
  - Feed 5,10,15,20,25,30 with full handshakes → m_data 5,15,30,50,70,90.
  - Each result appears 4 edges after its accept edge; s_ready is low while busy.
- Write c={1,2,3,4} in IDLE, then feed 1,0,0,0 → outputs 1,2,3,4 (impulse response).
- Saturation:
  - c all 127, feed 127 ×4 → final output 32767 (raw 64516).
  - Then reset, c all 127, feed -128 ×4 → -32768.
- Backpressure: hold m_ready=0 for 6 cycles in DONE → m_valid and m_data stable, s_ready=0, an offered s_valid is not taken. Release → next sample accepted in IDLE.
- Coef write during RUN → coefficient unchanged (next output matches old coefs), coef_err high exactly one cycle.
- Reset pulse mid-RUN → m_valid=0 and s_ready=1 immediately. After release, feed 7 → output 7 (history cleared, coefs back to 1).
